// File: rtl/inst_decoder.sv
// inst_decoder: RV32I instruction word -> stage-s0 microcode and instruction-data field
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   inst_in             fetched instruction word, valid when inst_valid=1
//   inst_valid          inst_in holds a real fetched instruction
//   block_inst          control_unit stall request; forces a bubble
//   microcode_s0        registered microcode word (RESET_MICROCODE on reset/bubble)
//   instruction_data_s0 registered inst_in[31:7] on issue, 0 otherwise
//   illegal_inst        sticky flag, set when an illegal word is issued
//   issue_count         (INST_DECODER_PERF_EN only) issue edges, wraps at 2^32
//   bubble_count        (INST_DECODER_PERF_EN only) bubble edges, wraps at 2^32
module inst_decoder #(
    parameter logic [31:0] RESET_MICROCODE = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_in,
    input  logic        inst_valid,
    input  logic        block_inst,
    output logic [31:0] microcode_s0,
    output logic [24:0] instruction_data_s0,
    output logic        illegal_inst
`ifdef INST_DECODER_PERF_EN
    ,
    output logic [31:0] issue_count,
    output logic [31:0] bubble_count
`endif
);
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23;
    localparam logic [6:0] OP_IMM = 7'h13, OP = 7'h33, FENCE = 7'h0f, SYSTEM = 7'h73;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3, cmp, br_cmp;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  alu_f3, alu_op;
    logic [1:0]  a_sel, b_sel;
    logic        chk1, chk2, use_alu, mem_we, addr, jump, mem_use, reg_we, up, aor, ret, mdo, ill;
    logic [31:0] decoded;
    logic        issue;
    assign opcode = inst_in[6:0];
    assign rd     = inst_in[11:7];
    assign f3     = inst_in[14:12];
    assign rs1    = inst_in[19:15];
    assign rs2    = inst_in[24:20];
    assign f7     = inst_in[31:25];
    assign issue  = inst_valid && !block_inst;
    // EQ/NE map to 1/2, LT..GEU (funct3 1xx) map to 3..6
    assign br_cmp = f3[2] ? 3'(f3[1:0]) + 3'd3 : 3'(f3[0]) + 3'd1;
    always_comb begin
        case (f3)
            3'd0:    alu_f3 = {3'b0, opcode == OP && f7[5]};
            3'd1:    alu_f3 = 4'd2;
            3'd2:    alu_f3 = 4'd3;
            3'd3:    alu_f3 = 4'd4;
            3'd4:    alu_f3 = 4'd5;
            3'd5:    alu_f3 = f7[5] ? 4'd7 : 4'd6;
            3'd6:    alu_f3 = 4'd8;
            default: alu_f3 = 4'd9;
        endcase
        alu_op = (opcode == OP || opcode == OP_IMM) ? alu_f3 : 4'd0;
    end
    always_comb begin
        chk1 = 1'b0; chk2 = 1'b0; a_sel = 2'd0; b_sel = 2'd0; use_alu = 1'b0; cmp = 3'd0;
        mem_we = 1'b0; addr = 1'b0; jump = 1'b0; mem_use = 1'b0; reg_we = 1'b0;
        up = 1'b0; aor = 1'b0; ret = 1'b0; mdo = 1'b0; ill = 1'b0;
        case (opcode)
            LUI:    begin reg_we = 1'b1; up = 1'b1; end
            AUIPC:  begin a_sel = 2'd1; b_sel = 2'd3; use_alu = 1'b1; reg_we = 1'b1; aor = 1'b1; end
            JAL:    begin a_sel = 2'd1; b_sel = 2'd3; use_alu = 1'b1; cmp = 3'd7; jump = 1'b1; reg_we = 1'b1; ret = 1'b1; end
            JALR:   begin chk1 = 1'b1; b_sel = 2'd1; use_alu = 1'b1; cmp = 3'd7; jump = 1'b1; reg_we = 1'b1; ret = 1'b1; end
            BRANCH: begin
                chk1 = 1'b1; chk2 = 1'b1; a_sel = 2'd1; b_sel = 2'd3; use_alu = 1'b1; jump = 1'b1;
                cmp = br_cmp;
                ill = f3[2:1] == 2'b01;
            end
            LOAD:   begin chk1 = 1'b1; b_sel = 2'd1; use_alu = 1'b1; addr = 1'b1; mem_use = 1'b1; reg_we = 1'b1; mdo = 1'b1; end
            STORE:  begin chk1 = 1'b1; chk2 = 1'b1; b_sel = 2'd2; use_alu = 1'b1; mem_we = 1'b1; addr = 1'b1; mem_use = 1'b1; end
            OP_IMM: begin chk1 = 1'b1; b_sel = 2'd1; use_alu = 1'b1; reg_we = 1'b1; aor = 1'b1; end
            OP:     begin
                chk1 = 1'b1; chk2 = 1'b1; use_alu = 1'b1; reg_we = 1'b1; aor = 1'b1;
                // funct7=0x20 only selects SUB/SRA
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            FENCE, SYSTEM: ;
            default: ill = 1'b1;
        endcase
        // x0 never carries a dependency and is never written
        decoded = ill ? 32'h0 : {8'h0, mdo, ret, aor, up, reg_we & |rd, mem_use, jump, addr, mem_we,
                                 cmp, alu_op, use_alu, use_alu, b_sel, a_sel, chk2 & |rs2, chk1 & |rs1};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            microcode_s0        <= RESET_MICROCODE;
            instruction_data_s0 <= '0;
            illegal_inst        <= 1'b0;
        end else if (issue) begin
            microcode_s0        <= decoded;
            instruction_data_s0 <= inst_in[31:7];
            illegal_inst        <= illegal_inst | ill;
        end else begin
            microcode_s0        <= RESET_MICROCODE;
            instruction_data_s0 <= '0;
        end
    end
`ifdef INST_DECODER_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_count  <= '0;
            bubble_count <= '0;
        end else if (issue) begin
            issue_count  <= issue_count + 32'd1;
        end else begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_decoder.sv
// tb_inst_decoder: directed table plus randomized model check of inst_decoder
module tb_inst_decoder;
    logic        clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0, block_inst = 1'b0;
    logic [31:0] inst_in = 32'h0;
    logic [31:0] microcode_s0;
    logic [24:0] instruction_data_s0;
    logic        illegal_inst;
    int          errors = 0, checks = 0;
    logic        exp_ill = 1'b0;
    logic [31:0] exp_iss = 0, exp_bub = 0;
    int          alu_of[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int          cmp_of[8] = '{1, 2, 0, 0, 3, 4, 5, 6};
    int          ops[11]   = '{'h37, 'h17, 'h6f, 'h67, 'h63, 'h03, 'h23, 'h13, 'h33, 'h0f, 'h73};
`ifdef INST_DECODER_PERF_EN
    logic [31:0] issue_count, bubble_count;
`endif

    always #5 clk = ~clk;

    inst_decoder dut (
        .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .inst_valid(inst_valid), .block_inst(block_inst),
        .microcode_s0(microcode_s0), .instruction_data_s0(instruction_data_s0), .illegal_inst(illegal_inst)
`ifdef INST_DECODER_PERF_EN
        , .issue_count(issue_count), .bubble_count(bubble_count)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic        valid, block;
        logic [31:0] mc;
        logic [24:0] data;
        logic        ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-opcode base microcode words assembled by hand from the bit map, then adjusted
    function automatic logic [31:0] model(input logic [31:0] w, output logic ill);
        logic [31:0] m;
        logic [6:0]  op = w[6:0], f7 = w[31:25];
        int          f3 = int'(w[14:12]);
        int          a;
        a = alu_of[f3] + (((f3 == 0 && op == 7'h33 && f7[5]) || (f3 == 5 && f7[5])) ? 1 : 0);
        ill = 1'b0;
        m = 0;
        case (op)
            7'h37: m = 32'h0018_0000;
            7'h17: m = 32'h0028_00F4;
            7'h6f: m = 32'h004A_70F4;
            7'h67: m = 32'h004A_70D1;
            7'h63: if (f3 == 2 || f3 == 3) ill = 1'b1; else m = 32'h0002_00F7 + (32'(cmp_of[f3]) << 12);
            7'h03: m = 32'h008D_00D1;
            7'h23: m = 32'h0005_80E3;
            7'h13: m = 32'h0028_00D1 + (32'(a) << 8);
            7'h33: if (!(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) ill = 1'b1;
                   else m = 32'h0028_00C3 + (32'(a) << 8);
            7'h0f, 7'h73: m = 0;
            default: ill = 1'b1;
        endcase
        if (w[11:7] == 0)  m[19] = 1'b0;
        if (w[19:15] == 0) m[0]  = 1'b0;
        if (w[24:20] == 0) m[1]  = 1'b0;
        return ill ? 32'h0 : m;
    endfunction

    task automatic tick(input logic [31:0] w, input logic v, input logic b, input logic r);
        logic il;
        void'(model(w, il));
        inst_in = w; inst_valid = v; block_inst = b; rst_n = r;
        @(posedge clk);
        #1;
        if (!r) begin
            exp_ill = 1'b0; exp_iss = 0; exp_bub = 0;
        end else if (v && !b) begin
            exp_ill |= il; exp_iss++;
        end else begin
            exp_bub++;
        end
`ifdef INST_DECODER_PERF_EN
        chk("issue_count", issue_count, exp_iss);
        chk("bubble_count", bubble_count, exp_bub);
`endif
    endtask

    task automatic check_out(input string tag, input logic [31:0] mc, input logic [24:0] d, input logic il);
        chk({tag, ".microcode"}, microcode_s0, mc);
        chk({tag, ".inst_data"}, {7'b0, instruction_data_s0}, {7'b0, d});
        chk({tag, ".illegal"}, {31'b0, illegal_inst}, {31'b0, il});
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{32'h0051_0093, 1, 0, 32'h0028_00D1, 25'h00A201, 0};
        vecs[1] = '{32'h0020_81B3, 1, 1, 32'h0,         25'h0,      0};
        vecs[2] = '{32'h0020_81B3, 1, 0, 32'h0028_00C3, 25'h004103, 0};
        vecs[3] = '{32'h0020_81B3, 0, 0, 32'h0,         25'h0,      0};
        vecs[4] = '{32'h0010_0013, 1, 0, 32'h0020_00D0, 25'h002000, 0};
        vecs[5] = '{32'h0020_8463, 1, 0, 32'h0002_10F7, 25'h004108, 0};
        vecs[6] = '{32'hFFFF_FFFF, 1, 1, 32'h0,         25'h0,      0};
        vecs[7] = '{32'hFFFF_FFFF, 1, 0, 32'h0,         25'h1FFFFFF, 1};
        vecs[8] = '{32'h0051_0093, 1, 0, 32'h0028_00D1, 25'h00A201, 1};
        vecs[9] = '{32'h0000_0000, 0, 0, 32'h0,         25'h0,      1};

        tick(32'h0051_0093, 1, 0, 0);
        tick(32'h0051_0093, 1, 0, 0);
        check_out("reset", 0, 0, 0);
        foreach (vecs[i]) begin
            tick(vecs[i].inst, vecs[i].valid, vecs[i].block, 1);
            check_out($sformatf("vec%0d", i), vecs[i].mc, vecs[i].data, vecs[i].ill);
        end
        tick(32'h0051_0093, 1, 0, 0);
        check_out("midreset", 0, 0, 0);
        tick(32'h0000_0000, 0, 0, 1);
        check_out("after_reset", 0, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] w, em;
            logic        v, b, r, il;
            int          k;
            w = $urandom;
            k = $urandom_range(0, 12);
            if (k < 11) w[6:0] = 7'(ops[k]);
            if (w[6:0] == 7'h33) begin
                k = $urandom_range(0, 3);
                w[31:25] = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : w[31:25];
            end
            if ($urandom_range(0, 3) == 0) w[11:7] = 0;
            if ($urandom_range(0, 3) == 0) w[19:15] = 0;
            if ($urandom_range(0, 3) == 0) w[24:20] = 0;
            v = $urandom_range(0, 7) != 0;
            b = $urandom_range(0, 4) == 0;
            r = $urandom_range(0, 99) != 0;
            em = model(w, il);
            tick(w, v, b, r);
            if (r && v && !b) check_out("rand", em, w[31:7], exp_ill);
            else check_out("rand", 0, 0, exp_ill);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_decoder.md
Name: inst_decoder

Overview:
Converts a fetched 32-bit RV32I instruction word into the 32-bit microcode word and 25-bit instruction-data field consumed by control_unit at stage s0. Sits between instruction memory read data and control_unit. Honours control_unit's block_inst by injecting bubbles. Holds a sticky illegal-instruction flag.

Parameters:
- RESET_MICROCODE, 32'h0, value loaded into microcode_s0 on reset and for every bubble (all-zero = NOP)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- inst_in  input  32  instruction word for the current pc, valid when inst_valid=1
- inst_valid  input  1  inst_in holds a real fetched instruction
- block_inst  input  1  from control_unit; 1 = do not issue, inject a bubble
- microcode_s0  output  32  registered microcode to control_unit
- instruction_data_s0  output  25  registered inst_in[31:7]: rd=[4:0], funct3=[7:5], rs1=[12:8], rs2=[17:13]
- illegal_inst  output  1  sticky; set when an illegal instruction is issued

Behaviour:
- Reset: rst_n=0 at a clk edge -> microcode_s0=RESET_MICROCODE, instruction_data_s0=0, illegal_inst=0. Reset wins over all inputs, including mid-stream.
- Latency: 1 cycle. inst_in sampled at edge N appears on outputs after edge N.
- Issue: inst_valid=1 and block_inst=0 -> load decoded microcode and inst_in[31:7].
- Bubble: inst_valid=0 or block_inst=1 -> microcode_s0=RESET_MICROCODE, instruction_data_s0=0. No state is kept; control_unit rewinds pc to refetch.
- Microcode bit map:
  - [0] check_rs1; [1] check_rs2
  - [3:2] a_sel: 0=rs1, 1=pc
  - [5:4] b_sel: 0=rs2, 1=imm_i, 2=imm_s, 3=imm_u/b/j (format chosen downstream by opcode)
  - [6] a_to_alu; [7] b_to_alu; [11:8] alu_op; [14:12] cmp_op
  - [15] mem_we; [16] alu_out_to_mem_addr; [17] jump_if_branch; [18] mem_in_use; [19] reg_we
  - [20] up_to_reg; [21] alu_out_to_reg; [22] ret_addr_to_reg; [23] mem_data_out; [31:24] always 0
- alu_op: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - funct3 000->ADD, or SUB when OP and funct7[5]=1
  - 001->SLL, 010->SLT, 011->SLTU, 100->XOR
  - 101->SRL, or SRA when funct7[5]=1
  - 110->OR, 111->AND
- cmp_op:
  - BRANCH funct3: 000->1 (EQ), 001->2 (NE), 100->3 (LT), 101->4 (GE), 110->5 (LTU), 111->6 (GEU)
  - JAL/JALR -> 7 (TRUE); all other instructions -> 0
- Per opcode (bits [6] and [7] are set whenever the ALU is used):
  - LUI: reg_we, up_to_reg
  - AUIPC: a=pc, b=3, ADD, reg_we, alu_out_to_reg
  - JAL: a=pc, b=3, ADD, cmp 7, jump, reg_we, ret_addr_to_reg
  - JALR: check_rs1, a=rs1, b=1, ADD, cmp 7, jump, reg_we, ret_addr_to_reg
  - BRANCH: check_rs1, check_rs2, a=pc, b=3, ADD, cmp per funct3, jump
  - LOAD: check_rs1, a=rs1, b=1, ADD, alu_out_to_mem_addr, mem_in_use, reg_we, mem_data_out
  - STORE: check_rs1, check_rs2, a=rs1, b=2, ADD, mem_we, alu_out_to_mem_addr, mem_in_use
  - OP-IMM: check_rs1, b=1, alu per funct3, reg_we, alu_out_to_reg
  - OP: check_rs1, check_rs2, b=0, alu per funct3/funct7, reg_we, alu_out_to_reg
  - FENCE, ECALL/EBREAK: microcode 0, legal
- x0 handling:
  - rd=0 -> reg_we forced 0 (bits [20..23] may stay set)
  - rs1 field=0 -> check_rs1 forced 0; rs2 field=0 -> check_rs2 forced 0
  - Prevents false data-dependency stalls.
- Illegal cases:
  - inst_in[1:0]!=2'b11
  - unknown opcode
  - BRANCH funct3 010/011
  - OP with funct7 other than 0x00, or 0x20 on ADD/SRL funct3
  - Response: microcode 0; illegal_inst set only when actually issued (inst_valid=1, block_inst=0). Cleared only by reset.

Optional Feature:
- Macro: INST_DECODER_PERF_EN.
- Defined: adds output ports issue_count[31:0] and bubble_count[31:0], both reset to 0.
  - issue_count increments on each issue edge; bubble_count increments on each bubble edge.
  - Both wrap at 2^32 (0xFFFFFFFF -> 0).
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 with inst_in=0x00510093, inst_valid=1 -> microcode_s0=0, instruction_data_s0=0, illegal_inst=0.
- addi x1,x2,5 (0x00510093), valid, not blocked -> next cycle microcode_s0=0x002800D1, instruction_data_s0=0x00A201.
- block_inst=1 with a valid add -> microcode_s0=0, instruction_data_s0=0. Deassert -> the same add issues one cycle later.
- addi x0,x0,1 (0x00100013) -> reg_we=0, check_rs1=0, i.e. microcode_s0=0x002000D0.
- beq x1,x2,+8 (0x00208463) -> check bits 11, a=pc, b=3, cmp_op=1, jump=1; microcode_s0=0x000210F7.
- Word 0xFFFFFFFF with block_inst=1 -> illegal_inst stays 0. Same word with block_inst=0 -> illegal_inst=1 and stays 1 until rst_n=0.
